// File: rtl/boid_frame_writer_if.sv
// ---------------------------------------------------------------------------
// boid_frame_writer_if
//
// Bundles the signals that run between the frame writer, the BPUs, the VGA
// controller and the display RAM.
//
// Modports:
//   master : the frame writer itself
//            in  screen_end, boid_x, boid_y
//            out boid_sel, fb_clear, fb_we, fb_addr, busy, frame_count, overrun
//   slave  : the surrounding system (BPU mux, VGA controller, display RAM)
//            with the directions mirrored
// ---------------------------------------------------------------------------
interface boid_frame_writer_if #(
  parameter int BITS_FOR_BOIDS = 2,
  parameter int ADDR_WIDTH     = 19
) ();

  logic                      screen_end;
  logic [BITS_FOR_BOIDS-1:0] boid_sel;
  logic [9:0]                boid_x;
  logic [8:0]                boid_y;
  logic                      fb_clear;
  logic                      fb_we;
  logic [ADDR_WIDTH-1:0]     fb_addr;
  logic                      busy;
  logic [15:0]               frame_count;
  logic                      overrun;

  modport master (
    input  screen_end, boid_x, boid_y,
    output boid_sel, fb_clear, fb_we, fb_addr, busy, frame_count, overrun
  );

  modport slave (
    output screen_end, boid_x, boid_y,
    input  boid_sel, fb_clear, fb_we, fb_addr, busy, frame_count, overrun
  );

endinterface

// File: rtl/boid_frame_writer.sv
// ---------------------------------------------------------------------------
// boid_frame_writer
//
// Frame-update sequencer. On each end-of-screen pulse it clears the display
// RAM for one cycle, then visits every BPU in turn: it selects the BPU,
// latches its position, and writes a SPRITE_SIZE x SPRITE_SIZE square of set
// pixels, clipped to the visible area. Every pixel slot takes one cycle even
// when clipped, so the frame length never depends on boid positions.
//
// Ports:
//   clock  : system clock, everything on the rising edge
//   reset  : synchronous, active-high; abandons any frame in progress
//   bus    : boid_frame_writer_if.master
//            screen_end (in)  end-of-frame pulse from the VGA controller
//            boid_x/y   (in)  position of the BPU addressed by boid_sel
//            boid_sel   (out) BPU index being read
//            fb_clear   (out) one-cycle display RAM clear
//            fb_we      (out) pixel write strobe (data is always 1)
//            fb_addr    (out) y*VIDEO_WIDTH + x
//            busy       (out) frame update in progress
//            frame_count(out) completed frames, wraps at 16 bits
//            overrun    (out) sticky: screen_end seen while busy
// ---------------------------------------------------------------------------
module boid_frame_writer #(
  parameter int MAX_BOIDS      = 4,
  parameter int BITS_FOR_BOIDS = 2,
  parameter int VIDEO_WIDTH    = 640,
  parameter int VIDEO_HEIGHT   = 480,
  parameter int ADDR_WIDTH     = 19,
  parameter int SPRITE_SIZE    = 2
) (
  input logic                clock,
  input logic                reset,
  boid_frame_writer_if.master bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, LATCH, DRAW, DONE} state_t;

  localparam logic [BITS_FOR_BOIDS-1:0] LAST_BOID = BITS_FOR_BOIDS'(MAX_BOIDS - 1);
  localparam logic [2:0]                LAST_PIX  = 3'(SPRITE_SIZE - 1);
  localparam logic [10:0]               VIS_W     = 11'(VIDEO_WIDTH);
  localparam logic [9:0]                VIS_H     = 10'(VIDEO_HEIGHT);

  state_t                    state_q;
  logic [BITS_FOR_BOIDS-1:0] k_q;
  logic [BITS_FOR_BOIDS-1:0] boid_sel_q;
  logic [9:0]                bx_q;
  logic [8:0]                by_q;
  logic [2:0]                dx_q;
  logic [2:0]                dy_q;
  logic                      fb_clear_q;
  logic                      busy_q;
  logic [15:0]               frame_count_q;
  logic                      overrun_q;

  logic [10:0]           px;
  logic [9:0]            py;
  logic                  in_view;
  logic [ADDR_WIDTH-1:0] row_base;

  // Sequencer: state, pixel counters and all registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      k_q           <= '0;
      boid_sel_q    <= '0;
      bx_q          <= '0;
      by_q          <= '0;
      dx_q          <= '0;
      dy_q          <= '0;
      fb_clear_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      // A pulse arriving anywhere outside IDLE (DONE included) is dropped
      // and remembered until reset.
      if (bus.screen_end && state_q != IDLE) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (bus.screen_end) begin
            state_q    <= CLEAR;
            fb_clear_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        CLEAR: begin
          fb_clear_q <= 1'b0;
          k_q        <= '0;
          boid_sel_q <= '0;
          state_q    <= LATCH;
        end
        LATCH: begin
          bx_q    <= bus.boid_x;
          by_q    <= bus.boid_y;
          dx_q    <= '0;
          dy_q    <= '0;
          state_q <= DRAW;
        end
        DRAW: begin
          if (dx_q == LAST_PIX) begin
            dx_q <= '0;
            if (dy_q == LAST_PIX) begin
              dy_q <= '0;
              if (k_q == LAST_BOID) begin
                state_q <= DONE;
              end else begin
                k_q        <= k_q + 1'b1;
                boid_sel_q <= k_q + 1'b1;
                state_q    <= LATCH;
              end
            end else begin
              dy_q <= dy_q + 1'b1;
            end
          end else begin
            dx_q <= dx_q + 1'b1;
          end
        end
        DONE: begin
          frame_count_q <= frame_count_q + 16'd1;
          busy_q        <= 1'b0;
          boid_sel_q    <= '0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pixel coordinate and clipping, derived purely from latched position and
  // counters so boid_x/boid_y never reach fb_addr combinationally.
  always_comb begin
    px      = {1'b0, bx_q} + {8'b0, dx_q};
    py      = {1'b0, by_q} + {7'b0, dy_q};
    in_view = (state_q == DRAW) && (px < VIS_W) && (py < VIS_H);
  end

  // Row base address; the 640-wide case reduces to two shifts and an add.
  generate
    if (VIDEO_WIDTH == 640) begin : g_row_shift
      assign row_base = (ADDR_WIDTH'(py) << 9) + (ADDR_WIDTH'(py) << 7);
    end else begin : g_row_mult
      assign row_base = ADDR_WIDTH'(py) * ADDR_WIDTH'(VIDEO_WIDTH);
    end
  endgenerate

  assign bus.fb_we       = in_view;
  assign bus.fb_addr     = in_view ? (row_base + ADDR_WIDTH'(px)) : '0;
  assign bus.fb_clear    = fb_clear_q;
  assign bus.busy        = busy_q;
  assign bus.boid_sel    = boid_sel_q;
  assign bus.frame_count = frame_count_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_boid_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_boid_frame_writer
//
// Drives the frame writer cycle by cycle and compares every output against a
// timeline model: a frame accepted at cycle t0 occupies t0+1 .. t0+BUSY_LEN,
// boid k owns the slot starting at t0+2+k*(1+S*S), and each pixel of its
// square is expected (or clipped) from plain coordinate arithmetic.
// ---------------------------------------------------------------------------
module tb_boid_frame_writer;

  localparam int NB       = 4;
  localparam int S        = 2;
  localparam int VW       = 640;
  localparam int VH       = 480;
  localparam int SLOT     = 1 + S * S;
  localparam int BUSY_LEN = NB * SLOT + 2;

  logic clock = 1'b0;
  logic reset;

  boid_frame_writer_if #(.BITS_FOR_BOIDS(2), .ADDR_WIDTH(19)) bus ();

  boid_frame_writer #(
    .MAX_BOIDS(NB), .BITS_FOR_BOIDS(2), .VIDEO_WIDTH(VW),
    .VIDEO_HEIGHT(VH), .ADDR_WIDTH(19), .SPRITE_SIZE(S)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Behavioural BPU bank: the selected boid's position appears combinationally.
  logic [9:0] posX [NB];
  logic [8:0] posY [NB];
  assign bus.boid_x = posX[bus.boid_sel];
  assign bus.boid_y = posY[bus.boid_sel];

  int assertCount = 0;
  int failCount   = 0;

  // Model state: cycle number, start of the accepted frame, positions it
  // captured, completed frames and the sticky overrun flag.
  int cyc        = 0;
  int frameStart = -100;
  int frameX [NB];
  int frameY [NB];
  int frameCount = 0;
  int modelOverrun = 0;

  // Single comparison point: counts every check, reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: observed %0d, expected %0d",
               tag, cyc, observed, expected);
    end
  endtask

  function automatic bit modelBusy();
    int rel = cyc - frameStart;
    return (rel >= 1) && (rel <= BUSY_LEN);
  endfunction

  // One clock cycle: check this cycle's outputs at the falling edge, then
  // present screen_end/reset for the coming rising edge and advance the model.
  task automatic applyStimulus(input logic se, input logic rst);
    int rel, j, k, p, pix, x, y;
    logic eBusy, eClear, eWe, checkSel;
    logic [31:0] eAddr, eSel;
    @(negedge clock);
    rel      = cyc - frameStart;
    eBusy    = (rel >= 1) && (rel <= BUSY_LEN);
    eClear   = (rel == 1);
    eWe      = 1'b0;
    eAddr    = 0;
    eSel     = 0;
    checkSel = !eBusy;
    if (rel >= 2 && rel <= BUSY_LEN - 1) begin
      j        = rel - 2;
      k        = j / SLOT;
      p        = j % SLOT;
      checkSel = 1'b1;
      eSel     = k;
      if (p >= 1) begin
        pix = p - 1;
        x   = frameX[k] + pix % S;
        y   = frameY[k] + pix / S;
        if (x < VW && y < VH) begin
          eWe   = 1'b1;
          eAddr = y * VW + x;
        end
      end
    end
    checkOutput("fb_we", {31'b0, bus.fb_we}, {31'b0, eWe});
    checkOutput("fb_addr", {13'b0, bus.fb_addr}, eAddr);
    checkOutput("fb_clear", {31'b0, bus.fb_clear}, {31'b0, eClear});
    checkOutput("busy", {31'b0, bus.busy}, {31'b0, eBusy});
    checkOutput("frame_count", {16'b0, bus.frame_count}, frameCount);
    checkOutput("overrun", {31'b0, bus.overrun}, modelOverrun);
    if (checkSel) checkOutput("boid_sel", {30'b0, bus.boid_sel}, eSel);

    bus.screen_end = se;
    reset          = rst;
    if (rst) begin
      frameStart   = -100 - cyc;
      frameCount   = 0;
      modelOverrun = 0;
    end else begin
      if (rel == BUSY_LEN) frameCount = (frameCount + 1) % 65536;
      if (se) begin
        if (eBusy) begin
          modelOverrun = 1;
        end else begin
          frameStart = cyc;
          for (int b = 0; b < NB; b++) begin
            frameX[b] = posX[b];
            frameY[b] = posY[b];
          end
        end
      end
    end
    @(posedge clock);
    cyc++;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  // Mix of interior, edge-hugging and fully off-screen positions.
  task automatic randomizePositions();
    int r;
    for (int b = 0; b < NB; b++) begin
      r = $urandom_range(0, 7);
      if (r < 5) begin
        posX[b] = 10'($urandom_range(0, VW - 1));
        posY[b] = 9'($urandom_range(0, VH - 1));
      end else if (r == 5) begin
        posX[b] = 10'($urandom_range(VW - 4, VW - 1));
        posY[b] = 9'($urandom_range(VH - 4, VH - 1));
      end else if (r == 6) begin
        posX[b] = 10'($urandom_range(VW, 1023));
        posY[b] = 9'($urandom_range(0, 511));
      end else begin
        posX[b] = 10'($urandom_range(0, 1023));
        posY[b] = 9'($urandom_range(VH, 511));
      end
    end
  endtask

  // Directed scenarios first, then a long randomized run with sparse
  // screen_end pulses and occasional resets.
  initial begin
    logic se, rst;
    bus.screen_end = 1'b0;
    reset          = 1'b1;
    for (int b = 0; b < NB; b++) begin
      posX[b] = '0;
      posY[b] = '0;
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);

    idleCycles(2);

    posX[0] = 10; posY[0] = 20;
    posX[1] = 100; posY[1] = 50;
    posX[2] = 0; posY[2] = 0;
    posX[3] = 300; posY[3] = 200;
    applyStimulus(1'b1, 1'b0);
    idleCycles(BUSY_LEN + 2);

    posX[0] = 639; posY[0] = 479;
    posX[1] = 700; posY[1] = 10;
    posX[2] = 5; posY[2] = 5;
    posX[3] = 638; posY[3] = 100;
    applyStimulus(1'b1, 1'b0);
    idleCycles(BUSY_LEN + 2);

    randomizePositions();
    applyStimulus(1'b1, 1'b0);
    idleCycles(4);
    applyStimulus(1'b1, 1'b0);
    idleCycles(BUSY_LEN);

    applyStimulus(1'b0, 1'b1);
    idleCycles(1);
    applyStimulus(1'b1, 1'b0);
    idleCycles(BUSY_LEN - 1);
    applyStimulus(1'b1, 1'b0);
    randomizePositions();
    applyStimulus(1'b1, 1'b0);
    idleCycles(BUSY_LEN + 2);

    applyStimulus(1'b1, 1'b0);
    idleCycles(9);
    applyStimulus(1'b0, 1'b1);
    idleCycles(5);
    randomizePositions();
    applyStimulus(1'b1, 1'b0);
    idleCycles(BUSY_LEN + 2);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 249) == 0);
      se  = ($urandom_range(0, 9) == 0);
      if (se && !rst && !modelBusy()) randomizePositions();
      applyStimulus(se, rst);
    end
    idleCycles(BUSY_LEN + 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
